// File: rtl/myo_spi_pkg.sv
// Shared constants and types for the myo SPI frame responder.
// Frame layout: 5 command words (SOF, pwmRef, flags1, flags2, dummy) followed
// by 7 status words, 12 words in total in each direction.
package myo_spi_pkg;

    localparam logic [3:0]  FRAME_WORDS = 4'd12;
    localparam logic [3:0]  CMD_WORDS   = 4'd5;
    localparam logic [15:0] SOF_WORD    = 16'h8000;

    // Transmit slot indices for the status words; slots 0..4 carry zero.
    localparam logic [3:0] SLOT_POS_HI   = 4'd5;
    localparam logic [3:0] SLOT_POS_LO   = 4'd6;
    localparam logic [3:0] SLOT_VELOCITY = 4'd7;
    localparam logic [3:0] SLOT_CURRENT  = 4'd8;
    localparam logic [3:0] SLOT_SPRING   = 4'd9;
    localparam logic [3:0] SLOT_SENSOR1  = 4'd10;
    localparam logic [3:0] SLOT_SENSOR2  = 4'd11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        STATUS = 2'd2,
        DRAIN  = 2'd3
    } state_e;

endpackage

// File: rtl/myo_cmd_watchdog.sv
// Command watchdog: counts cycles since the last applied command and raises a
// single-cycle expire strobe on the edge where the count reaches CYCLES.
// The count then holds at CYCLES until the next clear.
// Only instantiated when MYO_CMD_WATCHDOG_EN is defined.
module myo_cmd_watchdog #(
    parameter int CYCLES = 5_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic expire
);

    localparam int         CW    = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(CYCLES);

    logic [CW-1:0] cnt_q;

    // Free-running count since the last command, saturating at the limit.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (cnt_q != LIMIT) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Strobe on the edge that moves the count onto the limit.
    assign expire = !clear && (cnt_q == (LIMIT - CW'(1)));

endmodule

// File: rtl/myo_spi_frame_responder.sv
// Slave-side responder for the 12-word myo SPI frame.
// Decodes the command words from the master and applies pwm_ref and both flag
// words atomically once the dummy word arrives; serves the status words from a
// snapshot taken when slave select rises.
// Optional feature macro: MYO_CMD_WATCHDOG_EN (command timeout forces pwm_ref
// to zero and pulses frame_error after WATCHDOG_CYCLES without a command).
module myo_spi_frame_responder
    import myo_spi_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 5_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ss_active,
    input  logic        rx_valid,
    input  logic [15:0] rx_word,
    input  logic        tx_req,
    input  logic        tx_ack,
    output logic [15:0] tx_word,
    output logic        tx_wren,
    input  logic [31:0] actual_position,
    input  logic [15:0] actual_velocity,
    input  logic [15:0] actual_current,
    input  logic [15:0] spring_displacement,
    input  logic [15:0] sensor1,
    input  logic [15:0] sensor2,
    output logic [15:0] pwm_ref,
    output logic [15:0] control_flags1,
    output logic [15:0] control_flags2,
    output logic        cmd_valid,
    output logic        frame_error,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [3:0]  rx_idx_q, rx_idx_d;
    logic [3:0]  tx_idx_q;
    logic        ss_prev_q;
    logic [15:0] tx_word_q;
    logic        tx_wren_q;
    logic [15:0] pwm_ref_q, flags1_q, flags2_q;
    logic [15:0] pwm_sh_q, flags1_sh_q, flags2_sh_q;
    logic [31:0] snap_pos_q;
    logic [15:0] snap_vel_q, snap_cur_q, snap_spring_q, snap_s1_q, snap_s2_q;
    logic        cmd_valid_q, frame_error_q, busy_q;

    logic        ss_rise, ss_fall;
    logic        apply, word_err, end_err, wdt_expire;
    logic [15:0] slot_word;

    assign ss_rise = ss_active && !ss_prev_q;
    assign ss_fall = !ss_active && ss_prev_q;

`ifdef MYO_CMD_WATCHDOG_EN
    myo_cmd_watchdog #(
        .CYCLES (WATCHDOG_CYCLES)
    ) u_cmd_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (apply),
        .expire (wdt_expire)
    );
`else
    // No watchdog in this build: pwm_ref holds its last commanded value.
    assign wdt_expire = 1'b0;
    if (WATCHDOG_CYCLES < 1) begin : g_wdt_cycles_unused
    end
`endif

    // Frame sequencing: word accounting first, then the frame-end decision,
    // so a word arriving with the ss fall still counts toward the frame.
    always_comb begin
        state_d  = state_q;
        rx_idx_d = rx_idx_q;
        apply    = 1'b0;
        word_err = 1'b0;
        end_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_rise) state_d = CMD;
            end
            CMD: begin
                if (rx_valid) begin
                    rx_idx_d = rx_idx_q + 4'd1;
                    if (rx_idx_q == 4'd0 && rx_word != SOF_WORD) begin
                        word_err = 1'b1;
                        state_d  = DRAIN;
                    end else if (rx_idx_q == CMD_WORDS - 4'd1) begin
                        apply   = 1'b1;
                        state_d = STATUS;
                    end
                end
            end
            STATUS: begin
                if (rx_valid) begin
                    if (rx_idx_q == FRAME_WORDS) begin
                        word_err = 1'b1;
                        state_d  = DRAIN;
                    end else begin
                        rx_idx_d = rx_idx_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
        if (ss_fall) begin
            // A frame already flagged (now in DRAIN) is not reported twice.
            end_err  = (state_q != IDLE) && (state_d != DRAIN) && (rx_idx_d != FRAME_WORDS);
            state_d  = IDLE;
            rx_idx_d = 4'd0;
        end
    end

    // Transmit slot contents, always taken from the per-frame snapshot.
    always_comb begin
        slot_word = 16'h0000;
        case (tx_idx_q)
            SLOT_POS_HI:   slot_word = snap_pos_q[31:16];
            SLOT_POS_LO:   slot_word = snap_pos_q[15:0];
            SLOT_VELOCITY: slot_word = snap_vel_q;
            SLOT_CURRENT:  slot_word = snap_cur_q;
            SLOT_SPRING:   slot_word = snap_spring_q;
            SLOT_SENSOR1:  slot_word = snap_s1_q;
            SLOT_SENSOR2:  slot_word = snap_s2_q;
            default:       slot_word = 16'h0000;
        endcase
    end

    // FSM state, command shadow/apply, snapshot and tx handshake registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            rx_idx_q      <= 4'd0;
            tx_idx_q      <= 4'd0;
            ss_prev_q     <= 1'b0;
            tx_word_q     <= 16'h0000;
            tx_wren_q     <= 1'b0;
            pwm_ref_q     <= 16'h0000;
            flags1_q      <= 16'h0000;
            flags2_q      <= 16'h0000;
            pwm_sh_q      <= 16'h0000;
            flags1_sh_q   <= 16'h0000;
            flags2_sh_q   <= 16'h0000;
            snap_pos_q    <= 32'h0;
            snap_vel_q    <= 16'h0000;
            snap_cur_q    <= 16'h0000;
            snap_spring_q <= 16'h0000;
            snap_s1_q     <= 16'h0000;
            snap_s2_q     <= 16'h0000;
            cmd_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            ss_prev_q     <= ss_active;
            state_q       <= state_d;
            rx_idx_q      <= rx_idx_d;
            busy_q        <= (state_d != IDLE);
            cmd_valid_q   <= apply;
            frame_error_q <= word_err || end_err || wdt_expire;

            if (state_q == IDLE && ss_rise) begin
                snap_pos_q    <= actual_position;
                snap_vel_q    <= actual_velocity;
                snap_cur_q    <= actual_current;
                snap_spring_q <= spring_displacement;
                snap_s1_q     <= sensor1;
                snap_s2_q     <= sensor2;
            end

            if (state_q == CMD && rx_valid) begin
                case (rx_idx_q)
                    4'd1: pwm_sh_q    <= rx_word;
                    4'd2: flags1_sh_q <= rx_word;
                    4'd3: flags2_sh_q <= rx_word;
                    default: ;
                endcase
            end

            if (apply) begin
                pwm_ref_q <= pwm_sh_q;
                flags1_q  <= flags1_sh_q;
                flags2_q  <= flags2_sh_q;
            end else if (wdt_expire) begin
                pwm_ref_q <= 16'h0000;
            end

            if (ss_fall) begin
                tx_wren_q <= 1'b0;
                tx_idx_q  <= 4'd0;
            end else if (tx_ack) begin
                tx_wren_q <= 1'b0;
                if (tx_idx_q != FRAME_WORDS) tx_idx_q <= tx_idx_q + 4'd1;
            end else if (tx_req && !tx_wren_q && tx_idx_q < FRAME_WORDS) begin
                tx_word_q <= slot_word;
                tx_wren_q <= 1'b1;
            end
        end
    end

    assign tx_word        = tx_word_q;
    assign tx_wren        = tx_wren_q;
    assign pwm_ref        = pwm_ref_q;
    assign control_flags1 = flags1_q;
    assign control_flags2 = flags2_q;
    assign cmd_valid      = cmd_valid_q;
    assign frame_error    = frame_error_q;
    assign busy           = busy_q;

endmodule
